fft_butterfly2: RTL and testbench
=================================

# fft_butterfly2

Radix-2 decimation-in-time butterfly for the 16-point FFT datapath, in signed fixed point. Computes out0 = in0 + W·in1 and out1 = in0 − W·in1 using one shared multiplier over several cycles. Also generates the divided clocks (÷16, ÷32) that pace the surrounding FFT stage logic. Starts one butterfly every 32 clock cycles.

## Interface
- WORD_SIZE, 16, width of every real/imaginary sample, two's complement
- FRACTION, 8, fractional bits (default Q8.8)

- i_clk  in  1  system clock; the only clock
- i_rst  in  1  reset, synchronous and active-high
- i_in0_re, i_in0_im  in  WORD_SIZE  input sample 0 (complex)
- i_in1_re, i_in1_im  in  WORD_SIZE  input sample 1 (complex)
- i_twiddle_re, i_twiddle_im  in  WORD_SIZE  twiddle factor W
- o_out0_re, o_out0_im  out  WORD_SIZE  in0 + W·in1
- o_out1_re, o_out1_im  out  WORD_SIZE  in0 − W·in1
- o_butterfly_done  out  1  one-cycle pulse when outputs update
- clk_divided16  out  1  i_clk ÷16, 50% duty
- clk_divided32  out  1  i_clk ÷32, 50% duty

## Operation
- Free-running 5-bit counter cnt, incremented every cycle.
- clk_divided16 = cnt[3]; clk_divided32 = cnt[4].
- FSM states and transitions:
  - IDLE: on cnt==0, capture all six inputs into registers and go to M0.
  - M0: compute in1.re·W.re.
  - M1: compute in1.im·W.im.
  - M2: compute in1.re·W.im.
  - M3: compute in1.im·W.re.
  - ADD: form the product P and the butterfly sums.
  - OUT: register the outputs, pulse done, return to IDLE.
- Inputs are sampled only at the capture edge. Later changes are ignored until the next capture.
- Arithmetic:
  - Each product is a signed 2·WORD_SIZE-bit value.
  - P.re = (rr − ii) >>> FRACTION; P.im = (ri + ir) >>> FRACTION.
  - Shifts are arithmetic, truncating toward −∞, then truncated to WORD_SIZE.
  - out0 = in0 + P and out1 = in0 − P, computed per component at WORD_SIZE.
  - Overflow wraps (default build).
- Outputs hold their last value between updates.

## Timing
- Reset values, while i_rst is high: cnt=0, FSM=IDLE, all o_out* = 0, o_butterfly_done=0, clk_divided16=0, clk_divided32=0.
- First rising edge after i_rst falls: cnt==0, so that edge captures the inputs.
- Latency: capture at edge N; outputs valid and o_butterfly_done high for exactly one cycle after edge N+6.
- Throughput: one butterfly per 32 cycles; the next capture is at edge N+32.
- Reset asserted mid-operation: computation aborts, all state goes to reset values, and no done pulse is produced.
- The FSM always completes within the 32-cycle window, so capture never collides with OUT.

## Configuration
- BUTTERFLY2_SAT_EN:
  - Defined: P components and out0/out1 saturate to [−2^(WORD_SIZE−1), 2^(WORD_SIZE−1)−1] instead of wrapping.
  - Undefined: plain two's-complement wrap.
  - Latency is identical in both builds.

## Structure
- Shared package fft_pkg holds:
  - default WORD_SIZE and FRACTION;
  - the butterfly FSM state enum (IDLE, M0–M3, ADD, OUT);
  - the fixed-point saturate helper.
- One natural sub-module: fft_clk_div. It owns the 5-bit counter, both divided clocks, and the cnt==0 capture strobe.

## Test plan
- Reset held 5 cycles: all outputs 0, both divided clocks 0, no done pulse.
- Zero-input case:
  - Stimulus: in0=(0x016A,0x00C9), in1=(0,0), W=(0x00B5,0x00B5), applied at reset release.
  - Response: out0=out1=(0x016A,0x00C9), with done 6 cycles after capture.
- General case:
  - Stimulus: in0=(0x016A,0x00C9), in1=(0xFE96,0x00C9), W=(0x0100,0xFE00).
  - Response: out0=(0x0192,0x0466), out1=(0x0142,0xFD2C).
- Divided clocks: period 16 and 32 cycles, 50% duty; done pulses exactly every 32 cycles.
- Overflow case:
  - Stimulus: in0=(0x7F00,0), in1=(0x0200,0), W=(0x0100,0).
  - Response: out0.re wraps to 0x8100 by default, or reads 0x7FFF with BUTTERFLY2_SAT_EN.
- Reset asserted 3 cycles after a capture: no done pulse, outputs return to 0, and capture resumes on the first cycle after release.

Source files
------------

// File: rtl/fft_pkg.sv
// ============================================================================
// Module      : fft_pkg
// Description : Shared word-size defaults, butterfly FSM states and the
//               fixed-point saturation helper for the radix-2 FFT datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int WORD_SIZE_DEF = 16;
    localparam int FRACTION_DEF  = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        ADD  = 3'd5,
        OUT  = 3'd6
    } bfly_state_t;

    // Clamp a wide signed value into the range of a width-bit two's-complement word.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                      input int                 width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_butterfly2_if.sv
// ============================================================================
// Module      : fft_butterfly2_if
// Description : Sample, twiddle and result bundle of the radix-2 butterfly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fft_butterfly2_if
    import fft_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
);

    logic [WORD_SIZE-1:0] i_in0_re;
    logic [WORD_SIZE-1:0] i_in0_im;
    logic [WORD_SIZE-1:0] i_in1_re;
    logic [WORD_SIZE-1:0] i_in1_im;
    logic [WORD_SIZE-1:0] i_twiddle_re;
    logic [WORD_SIZE-1:0] i_twiddle_im;
    logic [WORD_SIZE-1:0] o_out0_re;
    logic [WORD_SIZE-1:0] o_out0_im;
    logic [WORD_SIZE-1:0] o_out1_re;
    logic [WORD_SIZE-1:0] o_out1_im;
    logic                 o_butterfly_done;

    modport master (
        output i_in0_re, i_in0_im, i_in1_re, i_in1_im, i_twiddle_re, i_twiddle_im,
        input  o_out0_re, o_out0_im, o_out1_re, o_out1_im, o_butterfly_done
    );

    modport slave (
        input  i_in0_re, i_in0_im, i_in1_re, i_in1_im, i_twiddle_re, i_twiddle_im,
        output o_out0_re, o_out0_im, o_out1_re, o_out1_im, o_butterfly_done
    );

endinterface

`default_nettype wire

// File: rtl/fft_clk_div.sv
// ============================================================================
// Module      : fft_clk_div
// Description : Free-running 5-bit counter producing the /16 and /32 stage
//               clocks and the once-per-window capture strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_clk_div (
    input  wire  i_clk,
    input  wire  i_rst,
    output logic o_capture,
    output logic clk_divided16,
    output logic clk_divided32
);

    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    assign cnt_d = cnt_q + 5'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign clk_divided16 = cnt_q[3];
    assign clk_divided32 = cnt_q[4];
    assign o_capture     = (cnt_q == 5'd0);

endmodule

`default_nettype wire

// File: rtl/fft_butterfly2.sv
// ============================================================================
// Module      : fft_butterfly2
// Description : Radix-2 DIT butterfly, out0 = in0 + W*in1, out1 = in0 - W*in1,
//               one shared multiplier, one butterfly per 32-cycle window.
//               Define BUTTERFLY2_SAT_EN to saturate instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_butterfly2
    import fft_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int FRACTION  = FRACTION_DEF
) (
    input  wire                    i_clk,
    input  wire                    i_rst,
    fft_butterfly2_if.slave        bus,
    output logic                   clk_divided16,
    output logic                   clk_divided32
);

    localparam int PW = 2 * WORD_SIZE;

    typedef logic signed [WORD_SIZE-1:0] word_t;
    typedef logic signed [PW-1:0]        prod_t;

    bfly_state_t state_q, state_d;
    logic        w_capture;
    logic        done_q;

    word_t in0_re_q, in0_im_q, in1_re_q, in1_im_q, w_re_q, w_im_q;
    prod_t rr_q, ii_q, ri_q, ir_q;
    word_t sum0_re_q, sum0_im_q, sum1_re_q, sum1_im_q;
    word_t out0_re_q, out0_im_q, out1_re_q, out1_im_q;

    word_t w_mul_a, w_mul_b;
    prod_t w_mul_p;
    logic signed [63:0] w_pre_re, w_pre_im;
    word_t w_p_re, w_p_im;
    word_t w_sum0_re, w_sum0_im, w_sum1_re, w_sum1_im;

    // Reduce a wide signed intermediate to one word: wrap or saturate.
    function automatic word_t fit(input logic signed [63:0] v);
`ifdef BUTTERFLY2_SAT_EN
        logic signed [63:0] c;
        c = sat_clamp(v, WORD_SIZE);
        return c[WORD_SIZE-1:0];
`else
        return v[WORD_SIZE-1:0];
`endif
    endfunction

    fft_clk_div u_clk_div (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_capture     (w_capture),
        .clk_divided16 (clk_divided16),
        .clk_divided32 (clk_divided32)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_capture) state_d = M0;
            M0:      state_d = M1;
            M1:      state_d = M2;
            M2:      state_d = M3;
            M3:      state_d = ADD;
            ADD:     state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One multiplier, operands steered by the current product state.
    always_comb begin
        w_mul_a = in1_re_q;
        w_mul_b = w_re_q;
        case (state_q)
            M1: begin w_mul_a = in1_im_q; w_mul_b = w_im_q; end
            M2: begin w_mul_a = in1_re_q; w_mul_b = w_im_q; end
            M3: begin w_mul_a = in1_im_q; w_mul_b = w_re_q; end
            default: ;
        endcase
    end

    assign w_mul_p = PW'(w_mul_a) * PW'(w_mul_b);

    always_comb begin
        w_pre_re  = (64'(rr_q) - 64'(ii_q)) >>> FRACTION;
        w_pre_im  = (64'(ri_q) + 64'(ir_q)) >>> FRACTION;
        w_p_re    = fit(w_pre_re);
        w_p_im    = fit(w_pre_im);
        w_sum0_re = fit(64'(in0_re_q) + 64'(w_p_re));
        w_sum0_im = fit(64'(in0_im_q) + 64'(w_p_im));
        w_sum1_re = fit(64'(in0_re_q) - 64'(w_p_re));
        w_sum1_im = fit(64'(in0_im_q) - 64'(w_p_im));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            in0_re_q  <= '0; in0_im_q  <= '0;
            in1_re_q  <= '0; in1_im_q  <= '0;
            w_re_q    <= '0; w_im_q    <= '0;
            rr_q      <= '0; ii_q      <= '0;
            ri_q      <= '0; ir_q      <= '0;
            sum0_re_q <= '0; sum0_im_q <= '0;
            sum1_re_q <= '0; sum1_im_q <= '0;
            out0_re_q <= '0; out0_im_q <= '0;
            out1_re_q <= '0; out1_im_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_capture) begin
                        in0_re_q <= bus.i_in0_re;
                        in0_im_q <= bus.i_in0_im;
                        in1_re_q <= bus.i_in1_re;
                        in1_im_q <= bus.i_in1_im;
                        w_re_q   <= bus.i_twiddle_re;
                        w_im_q   <= bus.i_twiddle_im;
                    end
                end
                M0: rr_q <= w_mul_p;
                M1: ii_q <= w_mul_p;
                M2: ri_q <= w_mul_p;
                M3: ir_q <= w_mul_p;
                ADD: begin
                    sum0_re_q <= w_sum0_re;
                    sum0_im_q <= w_sum0_im;
                    sum1_re_q <= w_sum1_re;
                    sum1_im_q <= w_sum1_im;
                end
                OUT: begin
                    out0_re_q <= sum0_re_q;
                    out0_im_q <= sum0_im_q;
                    out1_re_q <= sum1_re_q;
                    out1_im_q <= sum1_im_q;
                    done_q    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_out0_re        = out0_re_q;
    assign bus.o_out0_im        = out0_im_q;
    assign bus.o_out1_re        = out1_re_q;
    assign bus.o_out1_im        = out1_im_q;
    assign bus.o_butterfly_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_butterfly2.sv
// ============================================================================
// Module      : tb_fft_butterfly2
// Description : Scoreboard bench for the radix-2 butterfly and its divided
//               clocks; expectations follow BUTTERFLY2_SAT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_butterfly2;

    localparam int W = 16;

    typedef struct packed {
        logic [15:0] o0r;
        logic [15:0] o0i;
        logic [15:0] o1r;
        logic [15:0] o1i;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d16;
    logic d32;

    res_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fft_butterfly2_if #(.WORD_SIZE(W)) bus ();

    fft_butterfly2 #(.WORD_SIZE(W), .FRACTION(8)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (bus),
        .clk_divided16 (d16),
        .clk_divided32 (d32)
    );

    function automatic longint fitw(input longint v);
`ifdef BUTTERFLY2_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        logic [15:0] t;
        t = v[15:0];
        return longint'($signed(t));
`endif
    endfunction

    function automatic res_t model(input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i);
        longint rr, ii, ri, ir, pr, pi, ar, ai;
        longint s0r, s0i, s1r, s1i;
        res_t   r;
        ar  = longint'($signed(a_r));
        ai  = longint'($signed(a_i));
        rr  = longint'($signed(b_r)) * longint'($signed(w_r));
        ii  = longint'($signed(b_i)) * longint'($signed(w_i));
        ri  = longint'($signed(b_r)) * longint'($signed(w_i));
        ir  = longint'($signed(b_i)) * longint'($signed(w_r));
        pr  = fitw((rr - ii) >>> 8);
        pi  = fitw((ri + ir) >>> 8);
        s0r = fitw(ar + pr);
        s0i = fitw(ai + pi);
        s1r = fitw(ar - pr);
        s1i = fitw(ai - pi);
        r.o0r = s0r[15:0];
        r.o0i = s0i[15:0];
        r.o1r = s1r[15:0];
        r.o1i = s1i[15:0];
        return r;
    endfunction

    task automatic apply(input logic [15:0] a_r, a_i, b_r, b_i, w_r, w_i);
        bus.i_in0_re     = a_r;
        bus.i_in0_im     = a_i;
        bus.i_in1_re     = b_r;
        bus.i_in1_im     = b_i;
        bus.i_twiddle_re = w_r;
        bus.i_twiddle_im = w_i;
    endtask

    // Called at a negedge whose following posedge is a capture edge.
    task automatic run_vector(input string name);
        res_t        got;
        res_t        exp_r;
        logic [4:0]  cnt;
        logic        exp_done;
        @(posedge clk);
        #1;
        apply(16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom));
        for (int i = 1; i < 32; i++) begin
            @(posedge clk);
            @(negedge clk);
            cnt      = 5'(i + 1);
            exp_done = (i == 6);
            n_vec++;
            if ({d32, d16} !== {cnt[4], cnt[3]}) begin
                n_err++;
                $display("FAIL %s divclk cyc%0d: got d32/d16=%b%b want %b%b",
                         name, i, d32, d16, cnt[4], cnt[3]);
            end
            n_vec++;
            if (bus.o_butterfly_done !== exp_done) begin
                n_err++;
                $display("FAIL %s done cyc%0d: got %b want %b",
                         name, i, bus.o_butterfly_done, exp_done);
            end
            if (exp_done) begin
                got = {bus.o_out0_re, bus.o_out0_im, bus.o_out1_re, bus.o_out1_im};
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL %s scoreboard empty, got %h", name, got);
                end else begin
                    exp_r = sb.pop_front();
                    if (got !== exp_r) begin
                        n_err++;
                        $display("FAIL %s outputs: got out0=(%h,%h) out1=(%h,%h) want out0=(%h,%h) out1=(%h,%h)",
                                 name, got.o0r, got.o0i, got.o1r, got.o1i,
                                 exp_r.o0r, exp_r.o0i, exp_r.o1r, exp_r.o1i);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        logic seen_done;
        seen_done = 1'b0;
        rst = 1'b1;
        apply(16'h016A, 16'h00C9, 16'h0000, 16'h0000, 16'h00B5, 16'h00B5);
        repeat (5) begin
            @(negedge clk);
            if (bus.o_butterfly_done) seen_done = 1'b1;
        end
        n_vec++;
        if ({bus.o_out0_re, bus.o_out0_im, bus.o_out1_re, bus.o_out1_im} !== 64'h0) begin
            n_err++;
            $display("FAIL reset outputs: got %h want 0",
                     {bus.o_out0_re, bus.o_out0_im, bus.o_out1_re, bus.o_out1_im});
        end
        n_vec++;
        if ({d32, d16, seen_done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset d32/d16/done: got %b%b%b want 000", d32, d16, seen_done);
        end
    endtask

    task automatic test_zero_input();
        res_t e;
        e = {16'h016A, 16'h00C9, 16'h016A, 16'h00C9};
        sb.push_back(e);
        rst = 1'b0;
        run_vector("zero_in1");
    endtask

    task automatic test_general();
        res_t e;
        apply(16'h016A, 16'h00C9, 16'hFE96, 16'h00C9, 16'h0100, 16'hFE00);
        e = {16'h0192, 16'h0466, 16'h0142, 16'hFD2C};
        sb.push_back(e);
        run_vector("general");
    endtask

    task automatic test_overflow();
        res_t e;
        apply(16'h7F00, 16'h0000, 16'h0200, 16'h0000, 16'h0100, 16'h0000);
`ifdef BUTTERFLY2_SAT_EN
        e = {16'h7FFF, 16'h0000, 16'h7D00, 16'h0000};
`else
        e = {16'h8100, 16'h0000, 16'h7D00, 16'h0000};
`endif
        sb.push_back(e);
        run_vector("overflow");
    endtask

    task automatic test_back_to_back();
        logic [15:0] v[6];
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 6; j++) v[j] = 16'($urandom);
            if (k == 0) begin
                v[2] = 16'h8000; v[3] = 16'h8000; v[4] = 16'h8000; v[5] = 16'h7FFF;
            end
            apply(v[0], v[1], v[2], v[3], v[4], v[5]);
            sb.push_back(model(v[0], v[1], v[2], v[3], v[4], v[5]));
            run_vector("back_to_back");
        end
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        seen_done = 1'b0;
        apply(16'h1234, 16'h5678, 16'h0300, 16'hFD00, 16'h0080, 16'h0040);
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            if (bus.o_butterfly_done) seen_done = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.o_butterfly_done) seen_done = 1'b1;
        end
        n_vec++;
        if (seen_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid done: got pulse want none");
        end
        n_vec++;
        if ({bus.o_out0_re, bus.o_out0_im, bus.o_out1_re, bus.o_out1_im, d32, d16} !== 66'h0) begin
            n_err++;
            $display("FAIL reset_mid state: got out=%h d32/d16=%b%b want 0",
                     {bus.o_out0_re, bus.o_out0_im, bus.o_out1_re, bus.o_out1_im}, d32, d16);
        end
        apply(16'hFF00, 16'h0100, 16'h0180, 16'hFE80, 16'h00B5, 16'hFF4B);
        sb.push_back(model(16'hFF00, 16'h0100, 16'h0180, 16'hFE80, 16'h00B5, 16'hFF4B));
        rst = 1'b0;
        run_vector("resume_after_reset");
    endtask

    initial begin
        test_reset();
        test_zero_input();
        test_general();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard leftover: got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
